// File: rtl/fetch_request_queue.sv
// In-order tracker between fetch and the I-cache: records issued PCs, matches returns against
// the oldest one, drops flushed responses. Optional macro FETCH_QUEUE_BYPASS_EN gives 0-latency outputs.
`timescale 1ns/1ps
module fetch_request_queue #(
    parameter int ADDRESS_BITS = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter int PTR_BITS     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [ADDRESS_BITS-1:0] req_address,
    output logic                    req_ready,
    input  logic                    flush,
    output logic                    mem_read,
    output logic [ADDRESS_BITS-1:0] mem_read_address,
    input  logic                    mem_valid,
    input  logic [ADDRESS_BITS-1:0] mem_out_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    inst_valid,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [PTR_BITS:0]       outstanding,
    output logic                    error
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [ADDRESS_BITS-1:0] addr_mem [DEPTH];
    logic [DEPTH-1:0]        kill_mem;
    logic [PTR_BITS-1:0]     rd_ptr;
    logic [PTR_BITS-1:0]     wr_ptr;
    logic [PTR_BITS:0]       count;
    logic [ADDRESS_BITS-1:0] pc_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    error_q;

    logic                    push;
    logic                    pop;
    logic [ADDRESS_BITS-1:0] head_addr;
    logic                    head_killed;
    logic                    addr_match;
    logic                    deliver;
    logic                    violation;

    // Request handshake: a read issues on a cycle where req_valid && req_ready; req_ready
    // depends only on occupancy, so a same-cycle return never frees a slot for a push.
    always_comb begin
        req_ready        = (count != FULL_COUNT);
        mem_read         = req_valid & req_ready;
        mem_read_address = req_address;
        push             = mem_read;
        pop              = mem_valid & (count != '0);
        head_addr        = addr_mem[rd_ptr];
        // A flush in the return cycle kills the popped entry as well.
        head_killed      = kill_mem[rd_ptr] | flush;
        addr_match       = (mem_out_addr == head_addr);
        deliver          = pop & ~head_killed & addr_match;
        violation        = (mem_valid & (count == '0)) | (pop & ~head_killed & ~addr_match);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= req_address;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kill_mem <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pc_q     <= '0;
            data_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            if (flush) begin
                kill_mem <= '1;
            end
            // Written after the flush so an entry pushed in the flush cycle survives.
            if (push) begin
                kill_mem[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (deliver) begin
                pc_q   <= head_addr;
                data_q <= mem_data;
            end
            if (violation) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign inst_valid  = deliver;
    assign inst_PC     = deliver ? head_addr : pc_q;
    assign instruction = deliver ? mem_data  : data_q;
`else
    logic valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= deliver;
        end
    end

    assign inst_valid  = valid_q;
    assign inst_PC     = pc_q;
    assign instruction = data_q;
`endif

    assign outstanding = count;
    assign error       = error_q;

endmodule
